operand_bypass: RTL and testbench

- Stage directly downstream of the one-cycle-latency register file.
- Tracks the rs1/rs2 addresses presented to the register file, aligns them with the returned read data one cycle later, and resolves read-after-write hazards.
- Hazard sources are in-flight EX/MEM/WB results and the register file's read-before-write behaviour on the same edge.
- Drives forwarded operands to execute and raises a load-use stall request.

---
 rtl/operand_bypass_pkg.sv | 27 ++
 rtl/operand_bypass_if.sv | 68 ++++++
 rtl/operand_bypass_bypass_select.sv | 60 ++++++
 rtl/operand_bypass.sv | 141 ++++++++++++++
 tb/tb_operand_bypass.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/operand_bypass_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : operand_bypass_pkg
//  Description : Shared widths, the x0 index and the forwarding-source
//                encoding used by the operand bypass stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package operand_bypass_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // Architectural zero register index; reads are hardwired to zero.
    localparam logic [REG_ADDR_W-1:0] c_X0 = '0;

    // Which path supplied an operand; exported for debug and coverage.
    typedef enum logic [2:0] {
        SRC_ZERO   = 3'd0,
        SRC_EX     = 3'd1,
        SRC_MEM    = 3'd2,
        SRC_WB     = 3'd3,
        SRC_SHADOW = 3'd4,
        SRC_RF     = 3'd5
    } fwd_src_t;

endpackage : operand_bypass_pkg
`default_nettype wire

// File: rtl/operand_bypass_if.sv
`default_nettype none
// ============================================================================
//  Module      : operand_bypass_if
//  Description : Decode, register-file, forwarding and operand signals of
//                the operand bypass stage. The master side is the pipeline
//                around the stage; the slave side is the stage itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface operand_bypass_if
    import operand_bypass_pkg::*;
#(
    parameter int XLEN_P       = XLEN,
    parameter int REG_ADDR_W_P = REG_ADDR_W
);

    // Decode side
    logic                    dec_valid;
    logic [REG_ADDR_W_P-1:0] dec_rs1;
    logic [REG_ADDR_W_P-1:0] dec_rs2;
    logic                    dec_use_rs1;
    logic                    dec_use_rs2;
    logic                    stall;
    logic                    kill;

    // Register file read data (one cycle after the address)
    logic [XLEN_P-1:0]       rf_data_rs1;
    logic [XLEN_P-1:0]       rf_data_rs2;

    // In-flight results
    logic                    ex_wr_en;
    logic                    ex_is_load;
    logic [REG_ADDR_W_P-1:0] ex_rd;
    logic [XLEN_P-1:0]       ex_data;
    logic                    mem_wr_en;
    logic [REG_ADDR_W_P-1:0] mem_rd;
    logic [XLEN_P-1:0]       mem_data;
    logic                    wb_wr_en;
    logic [REG_ADDR_W_P-1:0] wb_rd;
    logic [XLEN_P-1:0]       wb_data;

    // Operands to execute
    logic                    op_valid;
    logic [XLEN_P-1:0]       op_rs1;
    logic [XLEN_P-1:0]       op_rs2;
    logic                    hazard_stall;
    fwd_src_t                op_src1;
    fwd_src_t                op_src2;

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
        output stall, kill, rf_data_rs1, rf_data_rs2,
        output ex_wr_en, ex_is_load, ex_rd, ex_data,
        output mem_wr_en, mem_rd, mem_data,
        output wb_wr_en, wb_rd, wb_data,
        input  op_valid, op_rs1, op_rs2, hazard_stall, op_src1, op_src2
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
        input  stall, kill, rf_data_rs1, rf_data_rs2,
        input  ex_wr_en, ex_is_load, ex_rd, ex_data,
        input  mem_wr_en, mem_rd, mem_data,
        input  wb_wr_en, wb_rd, wb_data,
        output op_valid, op_rs1, op_rs2, hazard_stall, op_src1, op_src2
    );

endinterface : operand_bypass_if
`default_nettype wire

// File: rtl/operand_bypass_bypass_select.sv
`default_nettype none
// ============================================================================
//  Module      : bypass_select
//  Description : Priority forwarding mux for one source operand. The
//                youngest in-flight producer wins; x0 always reads zero;
//                the shadow copy covers the register file returning the
//                pre-write value when read and write share an edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module bypass_select
    import operand_bypass_pkg::*;
#(
    parameter int XLEN_P       = XLEN,
    parameter int REG_ADDR_W_P = REG_ADDR_W
) (
    input  wire logic [REG_ADDR_W_P-1:0] i_src_idx,
    input  wire logic                    i_ex_wr_en,
    input  wire logic                    i_ex_is_load,
    input  wire logic [REG_ADDR_W_P-1:0] i_ex_rd,
    input  wire logic [XLEN_P-1:0]       i_ex_data,
    input  wire logic                    i_mem_wr_en,
    input  wire logic [REG_ADDR_W_P-1:0] i_mem_rd,
    input  wire logic [XLEN_P-1:0]       i_mem_data,
    input  wire logic                    i_wb_wr_en,
    input  wire logic [REG_ADDR_W_P-1:0] i_wb_rd,
    input  wire logic [XLEN_P-1:0]       i_wb_data,
    input  wire logic                    i_shadow_valid,
    input  wire logic [REG_ADDR_W_P-1:0] i_shadow_rd,
    input  wire logic [XLEN_P-1:0]       i_shadow_data,
    input  wire logic [XLEN_P-1:0]       i_rf_data,
    output logic      [XLEN_P-1:0]       o_data,
    output fwd_src_t                     o_src
);

    localparam logic [REG_ADDR_W_P-1:0] c_ZERO_IDX = '0;

    // First matching source wins; a load in EX has no data yet so it is skipped.
    always_comb begin
        o_data = i_rf_data;
        o_src  = SRC_RF;
        if (i_src_idx == c_ZERO_IDX) begin
            o_data = '0;
            o_src  = SRC_ZERO;
        end else if (i_ex_wr_en && !i_ex_is_load && (i_ex_rd == i_src_idx)) begin
            o_data = i_ex_data;
            o_src  = SRC_EX;
        end else if (i_mem_wr_en && (i_mem_rd == i_src_idx)) begin
            o_data = i_mem_data;
            o_src  = SRC_MEM;
        end else if (i_wb_wr_en && (i_wb_rd == i_src_idx)) begin
            o_data = i_wb_data;
            o_src  = SRC_WB;
        end else if (i_shadow_valid && (i_shadow_rd == i_src_idx)) begin
            o_data = i_shadow_data;
            o_src  = SRC_SHADOW;
        end
    end

endmodule : bypass_select
`default_nettype wire

// File: rtl/operand_bypass.sv
`default_nettype none
// ============================================================================
//  Module      : operand_bypass
//  Description : Stage after the one-cycle register file. Aligns the
//                decoded rs1/rs2 indices with the returned read data,
//                forwards in-flight EX/MEM/WB results and the same-edge
//                write shadow, and requests a stall on load-use hazards.
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_bypass
    import operand_bypass_pkg::*;
(
    input  wire logic        clock,
    input  wire logic        reset,
    operand_bypass_if.slave  bus
);

    // Stage registers aligned with RF read data
    logic                  r_s_valid;
    logic [REG_ADDR_W-1:0] r_s_rs1;
    logic [REG_ADDR_W-1:0] r_s_rs2;
    logic                  r_s_use1;
    logic                  r_s_use2;

    // Copy of the last RF write, for reads that raced it on the same edge
    logic                  r_shadow_valid;
    logic [REG_ADDR_W-1:0] r_shadow_rd;
    logic [XLEN-1:0]       r_shadow_data;

    logic                  w_hazard_stall;
    logic                  w_hold;
    logic                  w_op_valid;
    logic [XLEN-1:0]       w_res1;
    logic [XLEN-1:0]       w_res2;
    fwd_src_t              w_src1;
    fwd_src_t              w_src2;

    // A load in EX cannot forward yet; hold until it reaches MEM.
    always_comb begin
        w_hazard_stall = r_s_valid && bus.ex_wr_en && bus.ex_is_load &&
                         (bus.ex_rd != c_X0) &&
                         ((r_s_use1 && (bus.ex_rd == r_s_rs1)) ||
                          (r_s_use2 && (bus.ex_rd == r_s_rs2)));
        w_hold         = bus.stall || w_hazard_stall;
        w_op_valid     = r_s_valid && !w_hazard_stall && !bus.kill;
    end

    // Capture decode unless frozen; kill invalidates even while frozen.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s_valid <= 1'b0;
            r_s_rs1   <= '0;
            r_s_rs2   <= '0;
            r_s_use1  <= 1'b0;
            r_s_use2  <= 1'b0;
        end else begin
            if (bus.kill) begin
                r_s_valid <= 1'b0;
            end else if (!w_hold) begin
                r_s_valid <= bus.dec_valid;
            end
            if (!w_hold) begin
                r_s_rs1  <= bus.dec_rs1;
                r_s_rs2  <= bus.dec_rs2;
                r_s_use1 <= bus.dec_use_rs1;
                r_s_use2 <= bus.dec_use_rs2;
            end
        end
    end

    // Shadow tracks every RF write, stalled or not.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shadow_valid <= 1'b0;
            r_shadow_rd    <= '0;
            r_shadow_data  <= '0;
        end else begin
            r_shadow_valid <= bus.wb_wr_en && (bus.wb_rd != c_X0);
            r_shadow_rd    <= bus.wb_rd;
            r_shadow_data  <= bus.wb_data;
        end
    end

    bypass_select #(
        .XLEN_P       (XLEN),
        .REG_ADDR_W_P (REG_ADDR_W)
    ) u_sel_rs1 (
        .i_src_idx      (r_s_rs1),
        .i_ex_wr_en     (bus.ex_wr_en),
        .i_ex_is_load   (bus.ex_is_load),
        .i_ex_rd        (bus.ex_rd),
        .i_ex_data      (bus.ex_data),
        .i_mem_wr_en    (bus.mem_wr_en),
        .i_mem_rd       (bus.mem_rd),
        .i_mem_data     (bus.mem_data),
        .i_wb_wr_en     (bus.wb_wr_en),
        .i_wb_rd        (bus.wb_rd),
        .i_wb_data      (bus.wb_data),
        .i_shadow_valid (r_shadow_valid),
        .i_shadow_rd    (r_shadow_rd),
        .i_shadow_data  (r_shadow_data),
        .i_rf_data      (bus.rf_data_rs1),
        .o_data         (w_res1),
        .o_src          (w_src1)
    );

    bypass_select #(
        .XLEN_P       (XLEN),
        .REG_ADDR_W_P (REG_ADDR_W)
    ) u_sel_rs2 (
        .i_src_idx      (r_s_rs2),
        .i_ex_wr_en     (bus.ex_wr_en),
        .i_ex_is_load   (bus.ex_is_load),
        .i_ex_rd        (bus.ex_rd),
        .i_ex_data      (bus.ex_data),
        .i_mem_wr_en    (bus.mem_wr_en),
        .i_mem_rd       (bus.mem_rd),
        .i_mem_data     (bus.mem_data),
        .i_wb_wr_en     (bus.wb_wr_en),
        .i_wb_rd        (bus.wb_rd),
        .i_wb_data      (bus.wb_data),
        .i_shadow_valid (r_shadow_valid),
        .i_shadow_rd    (r_shadow_rd),
        .i_shadow_data  (r_shadow_data),
        .i_rf_data      (bus.rf_data_rs2),
        .o_data         (w_res2),
        .o_src          (w_src2)
    );

    // Operands are zeroed whenever they are not valid for execute.
    always_comb begin
        bus.op_valid     = w_op_valid;
        bus.hazard_stall = w_hazard_stall;
        bus.op_rs1       = w_op_valid ? w_res1 : '0;
        bus.op_rs2       = w_op_valid ? w_res2 : '0;
        bus.op_src1      = w_src1;
        bus.op_src2      = w_src2;
    end

endmodule : operand_bypass
`default_nettype wire

// File: tb/tb_operand_bypass.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_bypass
//  Description : Directed scoreboard bench for operand_bypass.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_bypass;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
    } exp_t;

    logic clock;
    logic reset;

    operand_bypass_if bus ();

    operand_bypass dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Per-cycle status expectations written by stimulus, read by the monitor.
    logic stat_en   = 1'b0;
    logic exp_valid = 1'b0;
    logic exp_haz   = 1'b0;
    logic final_chk = 1'b0;

    task automatic idle();
        bus.dec_valid   = 1'b0;
        bus.dec_rs1     = '0;
        bus.dec_rs2     = '0;
        bus.dec_use_rs1 = 1'b0;
        bus.dec_use_rs2 = 1'b0;
        bus.stall       = 1'b0;
        bus.kill        = 1'b0;
        bus.rf_data_rs1 = '0;
        bus.rf_data_rs2 = '0;
        bus.ex_wr_en    = 1'b0;
        bus.ex_is_load  = 1'b0;
        bus.ex_rd       = '0;
        bus.ex_data     = '0;
        bus.mem_wr_en   = 1'b0;
        bus.mem_rd      = '0;
        bus.mem_data    = '0;
        bus.wb_wr_en    = 1'b0;
        bus.wb_rd       = '0;
        bus.wb_data     = '0;
        stat_en         = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic dec(input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2);
        bus.dec_valid   = 1'b1;
        bus.dec_rs1     = r1;
        bus.dec_rs2     = r2;
        bus.dec_use_rs1 = u1;
        bus.dec_use_rs2 = u2;
    endtask

    task automatic rf(input logic [31:0] d1, input logic [31:0] d2);
        bus.rf_data_rs1 = d1;
        bus.rf_data_rs2 = d2;
    endtask

    task automatic expect_op(input logic [31:0] e1, input logic [31:0] e2);
        exp_t e;
        e.rs1 = e1;
        e.rs2 = e2;
        q.push_back(e);
    endtask

    task automatic expect_stat(input logic v, input logic h);
        stat_en   = 1'b1;
        exp_valid = v;
        exp_haz   = h;
    endtask

    // Monitor: pops one expectation per presented operand pair.
    always @(negedge clock) begin
        exp_t e;
        if (bus.op_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: op_valid=1 rs1=%h rs2=%h, required no output",
                         bus.op_rs1, bus.op_rs2);
            end else begin
                e = q.pop_front();
                if (bus.op_rs1 !== e.rs1 || bus.op_rs2 !== e.rs2) begin
                    errors++;
                    $display("FAIL sb_operands: got rs1=%h rs2=%h, required rs1=%h rs2=%h",
                             bus.op_rs1, bus.op_rs2, e.rs1, e.rs2);
                end
            end
        end
        if (stat_en) begin
            checks++;
            if (bus.op_valid !== exp_valid) begin
                errors++;
                $display("FAIL op_valid: got %b, required %b", bus.op_valid, exp_valid);
            end
            checks++;
            if (bus.hazard_stall !== exp_haz) begin
                errors++;
                $display("FAIL hazard_stall: got %b, required %b", bus.hazard_stall, exp_haz);
            end
            if (!exp_valid) begin
                checks++;
                if (bus.op_rs1 !== 32'h0 || bus.op_rs2 !== 32'h0) begin
                    errors++;
                    $display("FAIL zero_operands: got rs1=%h rs2=%h, required 0/0",
                             bus.op_rs1, bus.op_rs2);
                end
            end
        end
        if (final_chk) begin
            checks++;
            if (q.size() != 0) begin
                errors++;
                $display("FAIL sb_drain: %0d expected outputs never seen, required 0", q.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    initial begin
        idle();
        reset = 1'b1;

        // Reset state
        tick();
        expect_stat(1'b0, 1'b0);
        tick();
        reset = 1'b0;

        // Basic read, no writers
        dec(5'd5, 5'd6, 1'b1, 1'b1);
        tick();
        rf(32'h11, 32'h22);
        expect_op(32'h11, 32'h22);
        expect_stat(1'b1, 1'b0);

        // Same-edge write: RF returns stale data, shadow supplies new value
        tick();
        dec(5'd5, 5'd6, 1'b1, 1'b1);
        bus.wb_wr_en = 1'b1;
        bus.wb_rd    = 5'd5;
        bus.wb_data  = 32'hAAAA;
        tick();
        rf(32'h11, 32'h22);
        expect_op(32'hAAAA, 32'h22);

        // Priority EX > MEM > WB, stage frozen by stall
        tick();
        dec(5'd7, 5'd0, 1'b1, 1'b0);
        tick();
        rf(32'h77, 32'h99);
        bus.stall = 1'b1;
        bus.ex_wr_en = 1'b1;  bus.ex_rd = 5'd7;  bus.ex_data = 32'h1;
        bus.mem_wr_en = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 32'h2;
        bus.wb_wr_en = 1'b1;  bus.wb_rd = 5'd7;  bus.wb_data = 32'h3;
        expect_op(32'h1, 32'h0);
        tick();
        rf(32'h77, 32'h99);
        bus.stall = 1'b1;
        bus.mem_wr_en = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 32'h2;
        bus.wb_wr_en = 1'b1;  bus.wb_rd = 5'd7;  bus.wb_data = 32'h3;
        expect_op(32'h2, 32'h0);
        tick();
        rf(32'h77, 32'h99);
        bus.wb_wr_en = 1'b1;  bus.wb_rd = 5'd7;  bus.wb_data = 32'h3;
        expect_op(32'h3, 32'h0);

        // Load-use on rs2, resolved from MEM the next cycle
        tick();
        dec(5'd3, 5'd9, 1'b1, 1'b1);
        tick();
        rf(32'h33, 32'h99);
        bus.ex_wr_en = 1'b1; bus.ex_is_load = 1'b1; bus.ex_rd = 5'd9; bus.ex_data = 32'hDEAD;
        expect_stat(1'b0, 1'b1);
        tick();
        rf(32'h33, 32'h99);
        bus.mem_wr_en = 1'b1; bus.mem_rd = 5'd9; bus.mem_data = 32'hBEEF;
        expect_op(32'h33, 32'hBEEF);
        expect_stat(1'b1, 1'b0);

        // x0 guard: load to x0 neither forwards nor stalls
        tick();
        dec(5'd0, 5'd4, 1'b1, 1'b1);
        tick();
        rf(32'h55, 32'h44);
        bus.ex_wr_en = 1'b1; bus.ex_is_load = 1'b1; bus.ex_rd = 5'd0; bus.ex_data = 32'hFFFF_FFFF;
        expect_op(32'h0, 32'h44);
        expect_stat(1'b1, 1'b0);
        dec(5'd9, 5'd2, 1'b0, 1'b1);

        // Unused source matching a load: no hazard, still resolved from RF
        tick();
        rf(32'h99, 32'h22);
        bus.ex_wr_en = 1'b1; bus.ex_is_load = 1'b1; bus.ex_rd = 5'd9; bus.ex_data = 32'hDEAD;
        expect_op(32'h99, 32'h22);
        expect_stat(1'b1, 1'b0);

        // Kill during a load-use hazard
        tick();
        dec(5'd9, 5'd1, 1'b1, 1'b1);
        tick();
        rf(32'h99, 32'h10);
        bus.ex_wr_en = 1'b1; bus.ex_is_load = 1'b1; bus.ex_rd = 5'd9;
        bus.kill = 1'b1;
        expect_stat(1'b0, 1'b1);
        tick();
        rf(32'h99, 32'h10);
        bus.ex_wr_en = 1'b1; bus.ex_is_load = 1'b1; bus.ex_rd = 5'd9;
        expect_stat(1'b0, 1'b0);

        // Reset asserted while stalled
        tick();
        dec(5'd5, 5'd6, 1'b1, 1'b1);
        tick();
        rf(32'h11, 32'h22);
        bus.stall = 1'b1;
        reset = 1'b1;
        expect_op(32'h11, 32'h22);
        expect_stat(1'b1, 1'b0);
        tick();
        reset = 1'b0;
        bus.stall = 1'b1;
        dec(5'd5, 5'd6, 1'b1, 1'b1);
        rf(32'h11, 32'h22);
        expect_stat(1'b0, 1'b0);

        tick();
        tick();
        final_chk = 1'b1;
        repeat (5) @(posedge clock);
        $display("FAIL timeout: summary not reached, required monitor to finish");
        $fatal(1, "bench did not terminate");
    end

endmodule : tb_operand_bypass
`default_nettype wire
